// File: rtl/i_cache_pkg.sv
// Shared types and constants for the I-cache refill controller.
package i_cache_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INVAL = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        BOUND = 3'd4,
        BASE  = 3'd5,
        DONE  = 3'd6
    } refill_state_e;

    // Base value that makes the slice window empty (base above any bound).
    localparam logic [31:0] INVALID_BASE = 32'hFFFF_FFFF;

endpackage

// File: rtl/i_refill_perf_cnt.sv
// Saturating 32-bit event counter; only built when I_REFILL_PERF_EN is defined.
`ifdef I_REFILL_PERF_EN
module i_refill_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] cnt
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Increment on event, hold at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`endif

// File: rtl/i_cache_refill_ctrl.sv
// I-cache refill sequencer: invalidate window, burst-read one aligned block,
// write it into the slice, then program bound and base.
// Optional feature macro: I_REFILL_PERF_EN (adds perf_miss_cnt / perf_stall_cnt).
module i_cache_refill_ctrl
    import i_cache_pkg::*;
#(
    parameter int unsigned CACHE_WORDS = 256,
    parameter int unsigned MEM_LAT_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_address,
    input  logic        i_cache_miss,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        refill_enable,
    output logic [31:0] refill_address,
    output logic [31:0] refill_data,
    output logic [31:0] set_base_addr,
    output logic [31:0] set_bound_addr,
    output logic        base_addr_we,
    output logic        bound_addr_we,
    output logic        refill_error
`ifdef I_REFILL_PERF_EN
    ,
    output logic [31:0] perf_miss_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned IDX_W      = $clog2(CACHE_WORDS);
    localparam int unsigned LINE_SHIFT = IDX_W + 2;
    localparam int unsigned WAIT_W     = $clog2(MEM_LAT_MAX + 1);
    localparam logic [31:0] LINE_MASK  = 32'((64'd1 << LINE_SHIFT) - 64'd1);
    localparam logic [31:0] BOUND_OFS  = 32'(CACHE_WORDS * 4 - 4);

    refill_state_e state_q, state_d;

    logic [31:0]       miss_addr_q, miss_addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              refill_error_q, refill_error_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              refill_enable_q, refill_enable_d;
    logic [31:0]       refill_address_q, refill_address_d;
    logic [31:0]       refill_data_q, refill_data_d;
    logic [31:0]       set_base_q, set_base_d;
    logic [31:0]       set_bound_q, set_bound_d;
    logic              base_we_q, base_we_d;
    logic              bound_we_q, bound_we_d;

    logic [31:0] blk_base;
    logic [31:0] blk_bound;
    logic        miss_accept;
    logic        rsp_ok;
    logic        rsp_err;
    logic        timeout;
    logic        last_word;

    // Block window and per-cycle events.
    always_comb begin
        blk_base    = miss_addr_q & ~LINE_MASK;
        blk_bound   = blk_base + BOUND_OFS;
        miss_accept = (state_q == IDLE) && i_cache_miss;
        rsp_ok      = (state_q == WAIT) && mem_rvalid && !mem_err;
        rsp_err     = (state_q == WAIT) && mem_rvalid && mem_err;
        timeout     = (state_q == WAIT) && !mem_rvalid &&
                      (wait_cnt_q == WAIT_W'(MEM_LAT_MAX - 1));
        last_word   = (idx_q == IDX_W'(CACHE_WORDS - 1));
    end

    assign cpu_stall = (state_q != IDLE) || ((state_q == IDLE) && i_cache_miss);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (i_cache_miss) state_d = INVAL;
            INVAL: state_d = REQ;
            REQ:   if (mem_gnt) state_d = WAIT;
            WAIT: begin
                if (rsp_ok) begin
                    state_d = last_word ? BOUND : REQ;
                end else if (rsp_err || timeout) begin
                    state_d = IDLE;
                end
            end
            BOUND: state_d = BASE;
            BASE:  state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        mem_req_d        = (state_d == REQ);
        mem_addr_d       = '0;
        refill_enable_d  = rsp_ok;
        refill_address_d = '0;
        refill_data_d    = '0;
        base_we_d        = 1'b0;
        bound_we_d       = 1'b0;
        set_base_d       = set_base_q;
        set_bound_d      = set_bound_q;
        if (state_d == REQ) begin
            mem_addr_d = blk_base + 32'({idx_d, 2'b00});
        end
        if (rsp_ok) begin
            refill_address_d = 32'(idx_q);
            refill_data_d    = mem_rdata;
        end
        // Window writes trail their state by one cycle so they never overlap the last slot write.
        if (state_q == INVAL) begin
            base_we_d  = 1'b1;
            set_base_d = INVALID_BASE;
        end else if (state_q == BOUND) begin
            bound_we_d  = 1'b1;
            set_bound_d = blk_bound;
        end else if (state_q == BASE) begin
            base_we_d  = 1'b1;
            set_base_d = blk_base;
        end
    end

    // Datapath next values: miss address, word index, latency counter, sticky error.
    always_comb begin
        miss_addr_d    = miss_addr_q;
        idx_d          = idx_q;
        refill_error_d = refill_error_q;
        wait_cnt_d     = (state_q == WAIT) ? (wait_cnt_q + WAIT_W'(1)) : '0;
        if (miss_accept) begin
            miss_addr_d    = fetch_address;
            idx_d          = '0;
            refill_error_d = 1'b0;
        end
        if (rsp_ok) begin
            idx_d = idx_q + IDX_W'(1);
        end
        if (rsp_err || timeout) begin
            refill_error_d = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_addr_q      <= '0;
            idx_q            <= '0;
            wait_cnt_q       <= '0;
            refill_error_q   <= 1'b0;
            mem_req_q        <= 1'b0;
            mem_addr_q       <= '0;
            refill_enable_q  <= 1'b0;
            refill_address_q <= '0;
            refill_data_q    <= '0;
            set_base_q       <= '0;
            set_bound_q      <= '0;
            base_we_q        <= 1'b0;
            bound_we_q       <= 1'b0;
        end else begin
            miss_addr_q      <= miss_addr_d;
            idx_q            <= idx_d;
            wait_cnt_q       <= wait_cnt_d;
            refill_error_q   <= refill_error_d;
            mem_req_q        <= mem_req_d;
            mem_addr_q       <= mem_addr_d;
            refill_enable_q  <= refill_enable_d;
            refill_address_q <= refill_address_d;
            refill_data_q    <= refill_data_d;
            set_base_q       <= set_base_d;
            set_bound_q      <= set_bound_d;
            base_we_q        <= base_we_d;
            bound_we_q       <= bound_we_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign refill_enable  = refill_enable_q;
    assign refill_address = refill_address_q;
    assign refill_data    = refill_data_q;
    assign set_base_addr  = set_base_q;
    assign set_bound_addr = set_bound_q;
    assign base_addr_we   = base_we_q;
    assign bound_addr_we  = bound_we_q;
    assign refill_error   = refill_error_q;

`ifdef I_REFILL_PERF_EN
    // Miss and stall performance counters.
    i_refill_perf_cnt u_perf_miss (
        .clk (clk),
        .rst (rst),
        .inc (miss_accept),
        .cnt (perf_miss_cnt)
    );

    i_refill_perf_cnt u_perf_stall (
        .clk (clk),
        .rst (rst),
        .inc (cpu_stall),
        .cnt (perf_stall_cnt)
    );
`endif

endmodule
